// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the memory-port arbiter: memory bus types, arbiter preference
// and the load reorder-buffer entry.
package mem_port_arbiter_pkg;
  typedef logic [31:0] ADDR;
  typedef logic [63:0] MEM_BLOCK;
  typedef logic [3:0]  MEM_TAG;

  typedef enum logic [1:0] {
    MEM_NONE  = 2'h0,
    MEM_LOAD  = 2'h1,
    MEM_STORE = 2'h2
  } MEM_COMMAND;

  typedef enum logic {PREFER_LOAD = 1'b0, PREFER_STORE = 1'b1} ARB_PREF_T;

  typedef struct packed {
    logic     valid;
    logic     filled;
    MEM_TAG   tag;
    MEM_BLOCK data;
  } LD_ROB_ENTRY_T;

  localparam int MEM_ROB_DEPTH = 8;
endpackage

// File: rtl/mem_port_arbiter_rob.sv
// Load reorder buffer: allocates in issue order, fills out of order by tag (CAM),
// releases the head in order with a one-cycle registered response.
module load_reorder_buffer
  import mem_port_arbiter_pkg::*;
#(
  parameter int DEPTH = MEM_ROB_DEPTH,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             alloc,
  input  MEM_TAG           alloc_tag,
  input  MEM_TAG           fill_tag,
  input  MEM_BLOCK         fill_data,
  output logic             rel_valid,
  output MEM_BLOCK         rel_data,
  output logic             full,
  output logic [CNT_W-1:0] count,
  output logic             bad_tag
);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int PTR_W = IDX_W + 1;

  LD_ROB_ENTRY_T [DEPTH-1:0] r_ent;
  logic [PTR_W-1:0]          r_head, r_tail;
  logic                      r_rel_valid;
  MEM_BLOCK                  r_rel_data;

  logic [DEPTH-1:0]  w_hit;
  logic [IDX_W-1:0]  w_hidx, w_tidx;
  LD_ROB_ENTRY_T     w_head;
  logic              w_rel;
  MEM_BLOCK          w_rel_data;
  logic [PTR_W-1:0]  w_cnt;

  assign w_hidx = r_head[IDX_W-1:0];
  assign w_tidx = r_tail[IDX_W-1:0];
  assign w_head = r_ent[w_hidx];

  // Fill CAM: only pending, not-yet-filled entries can match a returning tag.
  for (genvar g = 0; g < DEPTH; g++) begin : g_cam
    assign w_hit[g] = (fill_tag != '0) && r_ent[g].valid && !r_ent[g].filled &&
                      (r_ent[g].tag == fill_tag);
  end

  assign bad_tag = (fill_tag != '0) && (w_hit == '0);

  // Head data arriving this cycle bypasses the entry so it releases next cycle.
  assign w_rel      = w_head.valid && (w_head.filled || w_hit[w_hidx]);
  assign w_rel_data = w_head.filled ? w_head.data : fill_data;

  assign full  = (r_head[IDX_W] != r_tail[IDX_W]) && (w_hidx == w_tidx);
  assign w_cnt = r_tail - r_head;
  assign count = CNT_W'(w_cnt);

  // Alloc and release never target the same slot: that would require a full ROB.
  for (genvar g = 0; g < DEPTH; g++) begin : g_ent
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        r_ent[g] <= '0;
      end else if (alloc && (w_tidx == IDX_W'(g))) begin
        r_ent[g] <= '{valid: 1'b1, filled: 1'b0, tag: alloc_tag, data: '0};
      end else if (w_rel && (w_hidx == IDX_W'(g))) begin
        r_ent[g] <= '0;
      end else if (w_hit[g]) begin
        r_ent[g].filled <= 1'b1;
        r_ent[g].data   <= fill_data;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_head      <= '0;
      r_tail      <= '0;
      r_rel_valid <= 1'b0;
      r_rel_data  <= '0;
    end else begin
      if (alloc) r_tail <= r_tail + 1'b1;
      if (w_rel) begin
        r_head     <= r_head + 1'b1;
        r_rel_data <= w_rel_data;
      end
      r_rel_valid <= w_rel;
    end
  end

  assign rel_valid = r_rel_valid;
  assign rel_data  = r_rel_data;
endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the memory port between the vector loader and the O-vector drain;
// loads are tracked in a reorder buffer and returned in issue order.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ROB_DEPTH = MEM_ROB_DEPTH,
  parameter int CNT_W     = $clog2(ROB_DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ld_req_valid,
  input  ADDR              ld_req_addr,
  output logic             ld_req_ready,
  input  logic             st_req_valid,
  input  ADDR              st_req_addr,
  input  MEM_BLOCK         st_req_data,
  output logic             st_req_ready,
  output logic             ld_resp_valid,
  output MEM_BLOCK         ld_resp_data,
  input  MEM_TAG           mem2proc_transaction_tag,
  input  MEM_BLOCK         mem2proc_data,
  input  MEM_TAG           mem2proc_data_tag,
  output MEM_COMMAND       proc2mem_command,
  output ADDR              proc2mem_addr,
  output MEM_BLOCK         proc2mem_data,
  output logic [CNT_W-1:0] outstanding_loads,
  output logic             idle,
  output logic             err_bad_tag
);
  ARB_PREF_T        r_pref, w_pref_nxt;
  logic             r_err_bad_tag;
  logic             w_full, w_bad_tag;
  logic             w_ld_elig, w_st_elig, w_gnt_ld, w_gnt_st, w_mem_acc;
  logic             w_acc_ld, w_acc_st;
  logic [CNT_W-1:0] w_cnt;

  assign w_ld_elig = ld_req_valid && !w_full;
  assign w_st_elig = st_req_valid;
  assign w_gnt_ld  = w_ld_elig && (!w_st_elig || (r_pref == PREFER_LOAD));
  assign w_gnt_st  = w_st_elig && !w_gnt_ld;
  assign w_mem_acc = (mem2proc_transaction_tag != '0);

  // Readys and the command are forced quiet while reset is held.
  assign w_acc_ld = rst && w_gnt_ld && w_mem_acc;
  assign w_acc_st = rst && w_gnt_st && w_mem_acc;

  assign ld_req_ready = w_acc_ld;
  assign st_req_ready = w_acc_st;

  always_comb begin
    proc2mem_command = MEM_NONE;
    proc2mem_addr    = '0;
    proc2mem_data    = '0;
    if (rst) begin
      if (w_gnt_ld) begin
        proc2mem_command = MEM_LOAD;
        proc2mem_addr    = ld_req_addr;
      end else if (w_gnt_st) begin
        proc2mem_command = MEM_STORE;
        proc2mem_addr    = st_req_addr;
        proc2mem_data    = st_req_data;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_pref <= PREFER_LOAD;
    else      r_pref <= w_pref_nxt;
  end

  // Preference flips only when memory actually takes the command.
  always_comb begin
    w_pref_nxt = r_pref;
    if (w_acc_ld)      w_pref_nxt = PREFER_STORE;
    else if (w_acc_st) w_pref_nxt = PREFER_LOAD;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)           r_err_bad_tag <= 1'b0;
    else if (w_bad_tag) r_err_bad_tag <= 1'b1;
  end

  load_reorder_buffer #(.DEPTH(ROB_DEPTH), .CNT_W(CNT_W)) u_rob (
    .clk       (clk),
    .rst       (rst),
    .alloc     (w_acc_ld),
    .alloc_tag (mem2proc_transaction_tag),
    .fill_tag  (mem2proc_data_tag),
    .fill_data (mem2proc_data),
    .rel_valid (ld_resp_valid),
    .rel_data  (ld_resp_data),
    .full      (w_full),
    .count     (w_cnt),
    .bad_tag   (w_bad_tag)
  );

  assign outstanding_loads = w_cnt;
  assign err_bad_tag       = r_err_bad_tag;
  assign idle              = !rst || (!ld_req_valid && !st_req_valid && (w_cnt == '0));
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed plus random bench for mem_port_arbiter against a queue-based model of
// the arbitration and in-order load return rules.
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  localparam int DEPTH = MEM_ROB_DEPTH;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic             clk, rst;
  logic             ld_req_valid, ld_req_ready, st_req_valid, st_req_ready;
  ADDR              ld_req_addr, st_req_addr, proc2mem_addr;
  MEM_BLOCK         st_req_data, ld_resp_data, mem2proc_data, proc2mem_data;
  logic             ld_resp_valid, idle, err_bad_tag;
  MEM_TAG           mem2proc_transaction_tag, mem2proc_data_tag;
  MEM_COMMAND       proc2mem_command;
  logic [CNT_W-1:0] outstanding_loads;

  mem_port_arbiter dut (
    .clk(clk), .rst(rst),
    .ld_req_valid(ld_req_valid), .ld_req_addr(ld_req_addr), .ld_req_ready(ld_req_ready),
    .st_req_valid(st_req_valid), .st_req_addr(st_req_addr), .st_req_data(st_req_data),
    .st_req_ready(st_req_ready), .ld_resp_valid(ld_resp_valid), .ld_resp_data(ld_resp_data),
    .mem2proc_transaction_tag(mem2proc_transaction_tag), .mem2proc_data(mem2proc_data),
    .mem2proc_data_tag(mem2proc_data_tag), .proc2mem_command(proc2mem_command),
    .proc2mem_addr(proc2mem_addr), .proc2mem_data(proc2mem_data),
    .outstanding_loads(outstanding_loads), .idle(idle), .err_bad_tag(err_bad_tag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  // Model state: issue-order tag queue, per-tag arrival flag and data.
  MEM_TAG   q[$];
  bit       have[16];
  MEM_BLOCK dat[16];
  bit       pref_load;
  bit       m_err;
  bit       exp_rv;
  MEM_BLOCK exp_rd;

  task automatic chk(input string nm, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", nm, obs, exp);
    end
  endtask

  function automatic bit in_q(input MEM_TAG t);
    foreach (q[i]) if (q[i] == t) return 1'b1;
    return 1'b0;
  endfunction

  function automatic MEM_TAG free_tag();
    MEM_TAG t;
    for (int k = 0; k < 32; k++) begin
      t = MEM_TAG'($urandom_range(1, 15));
      if (!in_q(t)) return t;
    end
    for (int k = 1; k < 16; k++) if (!in_q(MEM_TAG'(k))) return MEM_TAG'(k);
    return MEM_TAG'(1);
  endfunction

  task automatic model_clear();
    q.delete();
    for (int i = 0; i < 16; i++) begin have[i] = 1'b0; dat[i] = '0; end
    pref_load = 1'b1;
    m_err     = 1'b0;
    exp_rv    = 1'b0;
    exp_rd    = '0;
  endtask

  task automatic drive_idle();
    ld_req_valid = 0; ld_req_addr = '0; st_req_valid = 0; st_req_addr = '0; st_req_data = '0;
    mem2proc_transaction_tag = '0; mem2proc_data_tag = '0; mem2proc_data = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    drive_idle();
    #1;
    chk("rst_occ",  64'(outstanding_loads), 64'd0);
    chk("rst_cmd",  64'(proc2mem_command), 64'(MEM_NONE));
    chk("rst_addr", 64'(proc2mem_addr), 64'd0);
    chk("rst_lrdy", 64'(ld_req_ready), 64'd0);
    chk("rst_srdy", 64'(st_req_ready), 64'd0);
    chk("rst_idle", 64'(idle), 64'd1);
    chk("rst_rv",   64'(ld_resp_valid), 64'd0);
    chk("rst_err",  64'(err_bad_tag), 64'd0);
    model_clear();
    @(negedge clk);
    chk("rst_rd", ld_resp_data, 64'd0);
    rst = 1'b1;
  endtask

  // One clock: check registered outputs, drive inputs, check combinational outputs,
  // then advance the model by one cycle of spec rules.
  task automatic cyc(input bit lv, input ADDR la, input bit sv, input ADDR sa,
                     input MEM_BLOCK sd, input MEM_TAG tt, input MEM_TAG dt, input MEM_BLOCK dd);
    bit le, gl, gs, acc, found;
    MEM_COMMAND ecmd;
    @(negedge clk);
    chk("resp_valid", 64'(ld_resp_valid), 64'(exp_rv));
    if (exp_rv) chk("resp_data", ld_resp_data, exp_rd);
    chk("occupancy", 64'(outstanding_loads), 64'(q.size()));
    chk("err_bad_tag", 64'(err_bad_tag), 64'(m_err));
    ld_req_valid = lv; ld_req_addr = la; st_req_valid = sv; st_req_addr = sa; st_req_data = sd;
    mem2proc_transaction_tag = tt; mem2proc_data_tag = dt; mem2proc_data = dd;
    #1;
    le  = lv && (q.size() < DEPTH);
    gl  = le && (!sv || pref_load);
    gs  = sv && !gl;
    acc = (tt != 0);
    ecmd = gl ? MEM_LOAD : (gs ? MEM_STORE : MEM_NONE);
    chk("command", 64'(proc2mem_command), 64'(ecmd));
    chk("mem_addr", 64'(proc2mem_addr), gl ? 64'(la) : (gs ? 64'(sa) : 64'd0));
    chk("mem_data", proc2mem_data, gs ? sd : 64'd0);
    chk("ld_ready", 64'(ld_req_ready), 64'(gl && acc));
    chk("st_ready", 64'(st_req_ready), 64'(gs && acc));
    chk("idle", 64'(idle), 64'(!lv && !sv && q.size() == 0));
    if (dt != 0) begin
      found = in_q(dt) && !have[dt];
      if (found) begin have[dt] = 1'b1; dat[dt] = dd; end
      else m_err = 1'b1;
    end
    exp_rv = 1'b0;
    if (q.size() > 0 && have[q[0]]) begin
      exp_rv = 1'b1;
      exp_rd = dat[q[0]];
      have[q[0]] = 1'b0;
      void'(q.pop_front());
    end
    if (gl && acc) begin
      q.push_back(tt); have[tt] = 1'b0; pref_load = 1'b0;
    end else if (gs && acc) begin
      pref_load = 1'b1;
    end
  endtask

  task automatic nop(input int n);
    for (int i = 0; i < n; i++) cyc(0, '0, 0, '0, '0, '0, '0, '0);
  endtask

  task automatic ret(input MEM_TAG dt, input MEM_BLOCK dd);
    cyc(0, '0, 0, '0, '0, '0, dt, dd);
  endtask

  initial begin
    rst = 1'b0;
    drive_idle();
    model_clear();
    do_reset();

    // Single load, data returned four cycles later.
    cyc(1, 32'h1000, 0, '0, '0, 4'd3, '0, '0);
    nop(3);
    ret(4'd3, 64'hDEAD_BEEF);
    nop(2);

    // Contention after reset: LOAD first, then alternating.
    do_reset();
    for (int i = 1; i <= 4; i++)
      cyc(1, 32'h2000 + 32'(i * 8), 1, 32'h8000 + 32'(i * 8), 64'(i) * 64'h1111, MEM_TAG'(i), '0, '0);
    ret(4'd1, 64'hA1);
    ret(4'd3, 64'hA3);
    nop(2);

    // Store rejected three times, then accepted; next contention prefers the load.
    for (int i = 0; i < 3; i++) cyc(0, '0, 1, 32'h9000, 64'h55, 4'd0, '0, '0);
    cyc(0, '0, 1, 32'h9000, 64'h55, 4'd2, '0, '0);
    cyc(1, 32'h3000, 1, 32'h9008, 64'h66, 4'd4, '0, '0);
    ret(4'd4, 64'hB4);
    nop(2);

    // Out-of-order return 7,5,6 must come back 5,6,7.
    cyc(1, 32'h4000, 0, '0, '0, 4'd5, '0, '0);
    cyc(1, 32'h4008, 0, '0, '0, 4'd6, '0, '0);
    cyc(1, 32'h4010, 0, '0, '0, 4'd7, '0, '0);
    ret(4'd7, 64'hC7);
    nop(1);
    ret(4'd5, 64'hC5);
    ret(4'd6, 64'hC6);
    nop(3);

    // Fill the ROB; the ninth load stalls while stores proceed, then enters after a release.
    for (int i = 1; i <= DEPTH; i++) cyc(1, 32'h5000 + 32'(i * 8), 0, '0, '0, MEM_TAG'(i), '0, '0);
    cyc(1, 32'h5100, 1, 32'hA000, 64'h77, 4'd12, '0, '0);
    cyc(1, 32'h5100, 1, 32'hA008, 64'h78, 4'd12, '0, '0);
    cyc(1, 32'h5100, 0, '0, '0, 4'd12, 4'd1, 64'hD1);
    cyc(1, 32'h5100, 0, '0, '0, 4'd12, '0, '0);
    for (int i = 2; i <= DEPTH; i++) ret(MEM_TAG'(i), 64'hD0 + 64'(i));
    ret(4'd12, 64'hDC);
    nop(2);

    // Unknown tag sets a sticky error; reset with loads in flight clears everything.
    ret(4'd9, 64'hEE);
    nop(3);
    for (int i = 1; i <= 4; i++) cyc(1, 32'h6000 + 32'(i * 8), 0, '0, '0, MEM_TAG'(i), '0, '0);
    do_reset();
    ret(4'd2, 64'hF2);
    nop(2);

    // Random traffic.
    for (int n = 0; n < 400; n++) begin
      bit lv, sv;
      MEM_TAG tt, dt;
      MEM_TAG cand[$];
      lv = ($urandom_range(0, 3) != 0);
      sv = ($urandom_range(0, 2) == 0);
      tt = ($urandom_range(0, 3) == 0) ? MEM_TAG'(0) : free_tag();
      dt = '0;
      foreach (q[i]) if (!have[q[i]]) cand.push_back(q[i]);
      if (cand.size() > 0 && $urandom_range(0, 1) == 1)
        dt = cand[$urandom_range(0, cand.size() - 1)];
      cyc(lv, {$urandom_range(0, 32'h0FFF_FFFF), 3'b000}, sv, $urandom, {$urandom, $urandom},
          tt, dt, {$urandom, $urandom});
    end
    for (int n = 0; n < 12; n++) begin
      MEM_TAG dt;
      dt = '0;
      foreach (q[i]) if (!have[q[i]]) begin dt = q[i]; break; end
      ret(dt, {$urandom, $urandom});
    end
    nop(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
